// File: rtl/counter_pkg.sv
// Shared definitions for the counter/divider primitives.
package counter_pkg;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // Bits needed to hold values 0..v-1 (at least 1), for sizing WIDTH from MODULUS.
  function automatic int clog2(input longint unsigned v);
    longint unsigned x;
    int n;
    x = (v > 1) ? v - 1 : 1;
    n = 0;
    while (x != 0) begin
      n++;
      x = x >> 1;
    end
    return n;
  endfunction

endpackage

// File: rtl/mod_n_next.sv
// Combinational successor for a modulo-N up/down counter.
module mod_n_next
  import counter_pkg::*;
#(
  parameter int     WIDTH   = 4,
  parameter longint MODULUS = 16
) (
  input  logic [WIDTH-1:0] q_i,
  input  logic             up_i,
  output logic [WIDTH-1:0] nxt_o,
  output logic             will_wrap_o
);

  // MODULUS-1 always fits in WIDTH bits, including the full power-of-two case.
  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MODULUS - 1);

  // Explicit compare at both ends so power-of-two and non-power-of-two moduli
  // take the same path and produce identical wrap indication.
  always_comb begin
    nxt_o       = q_i;
    will_wrap_o = 1'b0;
    if (up_i == DIR_UP) begin
      if (q_i == MAX_V) begin
        nxt_o       = '0;
        will_wrap_o = 1'b1;
      end else begin
        nxt_o = q_i + WIDTH'(1);
      end
    end else begin
      if (q_i == '0) begin
        nxt_o       = MAX_V;
        will_wrap_o = 1'b1;
      end else begin
        nxt_o = q_i - WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/mod_n_updown_counter.sv
// Modulo-N up/down counter with clear, load, terminal count, wrap pulse and
// sticky out-of-range-load flag. Priority: sclr > load > en > hold.
module mod_n_updown_counter
  import counter_pkg::*;
#(
  parameter int     WIDTH       = 4,
  parameter longint MODULUS     = 16,
  parameter longint RESET_VALUE = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic             sclr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap,
  output logic             load_err
);

  // Parameter legality is checked at elaboration.
  if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
    $error("mod_n_updown_counter: WIDTH must be 1..32");
  end
  if (MODULUS < 2 || MODULUS > (64'd1 << WIDTH)) begin : g_bad_mod
    $error("mod_n_updown_counter: MODULUS must be 2..2**WIDTH");
  end
  if (RESET_VALUE < 0 || RESET_VALUE >= MODULUS) begin : g_bad_rst
    $error("mod_n_updown_counter: RESET_VALUE must be < MODULUS");
  end

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] RST_V = WIDTH'(RESET_VALUE);
  localparam logic [63:0]      MOD64 = 64'(MODULUS);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             wrap_q, wrap_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] step_val;
  logic             step_wrap;
  logic             load_oor;

  mod_n_next #(
    .WIDTH   (WIDTH),
    .MODULUS (MODULUS)
  ) u_next (
    .q_i         (cnt_q),
    .up_i        (up),
    .nxt_o       (step_val),
    .will_wrap_o (step_wrap)
  );

  // Zero-extend to 64 bits so MODULUS == 2**32 compares correctly.
  assign load_oor = ({{(64-WIDTH){1'b0}}, load_val} >= MOD64);

  // Next-state selection in priority order.
  always_comb begin
    cnt_d  = cnt_q;
    wrap_d = 1'b0;
    err_d  = err_q;
    if (sclr) begin
      cnt_d = '0;
      err_d = 1'b0;
    end else if (load) begin
      if (load_oor) begin
        cnt_d = MAX_V;
        err_d = 1'b1;
      end else begin
        cnt_d = load_val;
      end
    end else if (en) begin
      cnt_d  = step_val;
      wrap_d = step_wrap;
    end
  end

  // State registers, asynchronously reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q  <= RST_V;
      wrap_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      wrap_q <= wrap_d;
      err_q  <= err_d;
    end
  end

  // Terminal count is exactly "the next enabled step wraps", independent of en.
  assign tc       = step_wrap;
  assign q        = cnt_q;
  assign wrap     = wrap_q;
  assign load_err = err_q;

endmodule

// File: tb/tb_mod_n_updown_counter.sv
// Bench: two counters (4-bit mod-10 and 1-bit mod-2) share the control inputs;
// a modulo-arithmetic model is compared every negedge, plus literal checkpoints.
module tb_mod_n_updown_counter;

  logic       clk = 1'b0;
  logic       reset;
  logic       en, up, sclr, load;
  logic [3:0] load_val;

  logic [3:0] qa;
  logic       tca, wrapa, erra;
  logic [0:0] qb;
  logic       tcb, wrapb, errb;

  int n_tests = 0;
  int n_fail  = 0;

  // Model state: a = mod 10, b = mod 2
  int ma, mb;
  bit wa, wb, ea, eb;

  always #5 clk = ~clk;

  mod_n_updown_counter #(.WIDTH(4), .MODULUS(10), .RESET_VALUE(0)) dut_a (
    .clk(clk), .reset(reset), .en(en), .up(up), .sclr(sclr), .load(load),
    .load_val(load_val), .q(qa), .tc(tca), .wrap(wrapa), .load_err(erra)
  );

  mod_n_updown_counter #(.WIDTH(1), .MODULUS(2), .RESET_VALUE(0)) dut_b (
    .clk(clk), .reset(reset), .en(en), .up(up), .sclr(sclr), .load(load),
    .load_val(load_val[0:0]), .q(qb), .tc(tcb), .wrap(wrapb), .load_err(errb)
  );

  task automatic chk(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void mstep(input int md, input int lv, inout int m,
                                inout bit w, inout bit e);
    if (sclr) begin
      m = 0; w = 0; e = 0;
    end else if (load) begin
      if (lv < md) m = lv;
      else begin m = md - 1; e = 1; end
      w = 0;
    end else if (en) begin
      if (up) begin w = (m + 1 == md); m = (m + 1) % md; end
      else    begin w = (m == 0);      m = (m + md - 1) % md; end
    end else begin
      w = 0;
    end
  endfunction

  // Reference model update
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      ma = 0; wa = 0; ea = 0;
      mb = 0; wb = 0; eb = 0;
    end else begin
      mstep(10, int'(load_val), ma, wa, ea);
      mstep(2, int'(load_val[0]), mb, wb, eb);
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    chk("a.q",    qa,    ma);
    chk("a.tc",   tca,   up ? (ma == 9) : (ma == 0));
    chk("a.wrap", wrapa, wa);
    chk("a.err",  erra,  ea);
    chk("b.q",    qb,    mb);
    chk("b.tc",   tcb,   up ? (mb == 1) : (mb == 0));
    chk("b.wrap", wrapb, wb);
    chk("b.err",  errb,  eb);
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  initial begin
    reset = 1'b0; en = 0; up = 1; sclr = 0; load = 0; load_val = '0;
    #3;
    chk("rst.qa", qa, 0);
    chk("rst.wrapa", wrapa, 0);
    chk("rst.erra", erra, 0);
    #19 reset = 1'b1;   // released between edges at t=22

    // Count up from reset
    en = 1; up = 1;
    step(9);
    chk("up9.q", qa, 9);
    chk("up9.tc", tca, 1);
    chk("up9.wrap", wrapa, 0);
    step();
    chk("up_wrap.q", qa, 0);
    chk("up_wrap.wrap", wrapa, 1);
    step();
    chk("up_after.q", qa, 1);
    chk("up_after.wrap", wrapa, 0);

    // Direction change mid-count, then count down through 0
    up = 0;
    step();
    chk("dn.q0", qa, 0);
    chk("dn.tc", tca, 1);
    step();
    chk("dn_wrap.q", qa, 9);
    chk("dn_wrap.wrap", wrapa, 1);
    step();
    chk("dn.q8", qa, 8);

    // Out-of-range load clamps and sets sticky error
    en = 0; load = 1; load_val = 4'd12;
    step();
    chk("ld12.q", qa, 9);
    chk("ld12.err", erra, 1);
    load = 0; en = 1; up = 1;
    step(3);
    chk("sticky.q", qa, 2);
    chk("sticky.err", erra, 1);
    sclr = 1;
    step();
    chk("sclr.q", qa, 0);
    chk("sclr.err", erra, 0);

    // Priority: sclr over load over en
    sclr = 1; load = 1; en = 1; load_val = 4'd5;
    step();
    chk("prio1.q", qa, 0);
    sclr = 0;
    step();
    chk("prio2.q", qa, 5);
    chk("prio2.qb", qb, 1);

    // Asynchronous reset mid-count
    load_val = 4'd6;
    step();
    load = 0;
    step();
    chk("pre_rst.q", qa, 7);
    #2 reset = 1'b0;
    #1;
    chk("async.q", qa, 0);
    chk("async.wrap", wrapa, 0);
    @(posedge clk); #1;
    chk("rst_hold.q", qa, 0);
    #2 reset = 1'b1;
    step();
    chk("resume.q", qa, 1);

    // Toggle flip-flop behaviour on the 1-bit counter
    sclr = 1;
    step();
    sclr = 0; up = 1; en = 1;
    step();
    chk("tff1.q", qb, 1);
    chk("tff1.wrap", wrapb, 0);
    step();
    chk("tff2.q", qb, 0);
    chk("tff2.wrap", wrapb, 1);
    step();
    chk("tff3.q", qb, 1);
    en = 0;
    step(3);
    chk("hold.qb", qb, 1);
    chk("hold.wrapb", wrapb, 0);
    chk("hold.qa", qa, 3);
    en = 1;
    step();
    chk("tff4.q", qb, 0);
    chk("tff4.wrap", wrapb, 1);

    step(2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mod_n_updown_counter.md
Name: mod_n_updown_counter

Overview:
- Parametrised modulo-N synchronous up/down counter; successor to the single-bit toggle flip-flop used as a divide-by-2 element.
- Generalised in width and modulus; adds direction control, enable, synchronous clear, parallel load, terminal-count, wrap pulse and load-error flag.
- Used as the standard counter/divider primitive for timers, clock-enable generation and address sequencing in the datapath labs.

Parameters:
- WIDTH, 4, counter width in bits; legal range 1..32.
- MODULUS, 16, count range 0..MODULUS-1; legal range 2..2**WIDTH; out-of-range is an elaboration error.
- RESET_VALUE, 0, value of q after reset; must be < MODULUS.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- en  in  1  count enable.
- up  in  1  direction: 1 = increment, 0 = decrement.
- sclr  in  1  synchronous clear to 0.
- load  in  1  synchronous parallel load.
- load_val  in  WIDTH  value to load.
- q  out  WIDTH  current count, registered.
- tc  out  1  terminal count, combinational from q and up.
- wrap  out  1  registered one-cycle pulse on modulus wrap.
- load_err  out  1  sticky flag: a load with load_val >= MODULUS occurred.

Behaviour:
- Reset (reset=0, asynchronous, independent of clk): q=RESET_VALUE, wrap=0, load_err=0. Outputs hold while reset is low; the first active edge is the first rising clk after reset deasserts.
- Priority per rising edge: sclr > load > en > hold.
- sclr=1: q<=0, wrap<=0, load_err<=0.
- load=1 (sclr=0):
  - If load_val < MODULUS: q<=load_val.
  - Otherwise: q<=MODULUS-1 (clamped) and load_err<=1.
  - wrap<=0 in both cases.
- en=1 (sclr=0, load=0):
  - up=1: q<=(q==MODULUS-1) ? 0 : q+1.
  - up=0: q<=(q==0) ? MODULUS-1 : q-1.
  - wrap<=1 exactly when the wrap branch is taken, else 0.
- Idle (no control asserted): q holds, wrap<=0.
- Latency: q reflects a count/load/clear one cycle after the edge that samples it.
- tc = en-independent: (up && q==MODULUS-1) || (!up && q==0). It is the "next step wraps" indicator; cascade as next.en = en & tc.
- load_err is sticky; only reset or sclr clear it.
- Arithmetic is WIDTH bits with no carry-out port. When MODULUS==2**WIDTH, wrap is the natural overflow and no compare-reset is needed; the RTL must still produce wrap/tc identically.
- Direction change mid-count takes effect on the next enabled edge; no state is lost.
- WIDTH=1, MODULUS=2, up=1, en=1 must behave exactly as a toggle flip-flop (q alternates, wrap on every 1->0).
- No X on any output after reset for any input sequence.

Decomposition:
- Shared package counter_pkg:
  - DIR_UP=1'b1, DIR_DOWN=1'b0.
  - Function clog2 for callers sizing WIDTH from MODULUS.
- One sub-module: mod_n_next, purely combinational. Inputs q, up; outputs next value and will-wrap. Parametrised by WIDTH/MODULUS.
- The top holds the registers and priority muxing.

Test Plan:
- WIDTH=4, MODULUS=10, up=1, en=1 from reset: q runs 0..9,0. wrap=1 only in the cycle after 9->0. tc=1 while q==9.
- Same config, up=0: q runs 0,9,8..0. wrap pulses on 0->9. tc=1 while q==0.
- load=1, load_val=12 (MODULUS=10): q=9, load_err=1 and stays 1 through counting. sclr=1 -> q=0, load_err=0.
- sclr=1, load=1, en=1 in the same cycle: q=0. Next, load=1, en=1, load_val=5: q=5 with no count applied.
- Assert reset low mid-count at q=7, between clock edges: q goes to RESET_VALUE immediately, wrap=0. Release reset; counting resumes on the second edge from RESET_VALUE.
- WIDTH=1, MODULUS=2, en=1: q toggles every cycle, wrap pulses every other cycle. Toggle en low for 3 cycles: q holds.
